// File: rtl/alu_sequencer.sv
// Multicycle fetch/decode/execute controller for the 8-bit CPU. Fetches instruction
// bytes over a read handshake, drives the external combinational ALU and writes results back.
module alu_sequencer #(
    parameter logic [7:0] RESET_PC = 8'h00
) (
    input  logic       clk,
    input  logic       rst,
    output logic [7:0] mem_addr,
    output logic       mem_rd,
    input  logic       mem_ready,
    input  logic [7:0] mem_rdata,
    output logic [7:0] alu_a,
    output logic [7:0] alu_b,
    output logic [3:0] alu_op,
    input  logic [7:0] alu_y,
    output logic       halted,
    output logic [7:0] reg0
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_OPER   = 3'd3,
        S_HALT   = 3'd4
    } state_t;

    localparam logic [3:0] OP_LDI  = 4'h8;
    localparam logic [3:0] OP_JMP  = 4'h9;
    localparam logic [3:0] OP_JZ   = 4'hA;
    localparam logic [3:0] OP_HALT = 4'hF;

    state_t     state_reg;
    logic [7:0] pc_reg;
    logic [7:0] ir_reg;
    logic       zero_reg;
    logic [7:0] alu_a_reg;
    logic [7:0] alu_b_reg;
    logic [3:0] alu_op_reg;
    logic       halted_reg;

    logic [3:0] ir_op;
    logic [1:0] ir_dst;
    logic [1:0] ir_src;
    logic [7:0] pc_inc;

    assign ir_op  = ir_reg[7:4];
    assign ir_dst = ir_reg[3:2];
    assign ir_src = ir_reg[1:0];
    assign pc_inc = pc_reg + 8'd1;

    // Register file: write port shared by ALU write-back (EXEC) and LDI (OPER).
    logic       wr_en;
    logic [7:0] wr_data;
    logic [7:0] rf [4];

    always_comb begin
        wr_en   = 1'b0;
        wr_data = alu_y;
        if (state_reg == S_EXEC) begin
            wr_en   = 1'b1;
            wr_data = alu_y;
        end else if (state_reg == S_OPER && mem_ready && ir_op == OP_LDI) begin
            wr_en   = 1'b1;
            wr_data = mem_rdata;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_rf
            logic [7:0] r_reg;
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_reg <= 8'h00;
                end else if (wr_en && ir_dst == 2'(gi)) begin
                    r_reg <= wr_data;
                end
            end
            assign rf[gi] = r_reg;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= S_FETCH;
            pc_reg     <= RESET_PC;
            ir_reg     <= 8'h00;
            zero_reg   <= 1'b0;
            alu_a_reg  <= 8'h00;
            alu_b_reg  <= 8'h00;
            alu_op_reg <= 4'h0;
            halted_reg <= 1'b0;
        end else begin
            case (state_reg)
                S_FETCH: begin
                    if (mem_ready) begin
                        ir_reg    <= mem_rdata;
                        pc_reg    <= pc_inc;
                        state_reg <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    if (!ir_op[3]) begin
                        // Operands are captured here so dst==src needs no special case in EXEC.
                        alu_a_reg  <= rf[ir_dst];
                        alu_b_reg  <= rf[ir_src];
                        alu_op_reg <= {1'b0, ir_op[2:0]};
                        state_reg  <= S_EXEC;
                    end else if (ir_op == OP_LDI || ir_op == OP_JMP || ir_op == OP_JZ) begin
                        state_reg <= S_OPER;
                    end else if (ir_op == OP_HALT) begin
                        halted_reg <= 1'b1;
                        state_reg  <= S_HALT;
                    end else begin
                        state_reg <= S_FETCH;
                    end
                end
                S_EXEC: begin
                    zero_reg  <= (alu_y == 8'h00);
                    state_reg <= S_FETCH;
                end
                S_OPER: begin
                    if (mem_ready) begin
                        case (ir_op)
                            OP_JMP:  pc_reg <= mem_rdata;
                            OP_JZ:   pc_reg <= zero_reg ? mem_rdata : pc_inc;
                            default: pc_reg <= pc_inc;
                        endcase
                        state_reg <= S_FETCH;
                    end
                end
                S_HALT: begin
                    state_reg <= S_HALT;
                end
                default: begin
                    state_reg <= S_FETCH;
                end
            endcase
        end
    end

    // Read request is decoded from state but forced low while reset is held.
    assign mem_rd   = !rst && (state_reg == S_FETCH || state_reg == S_OPER);
    assign mem_addr = pc_reg;
    assign alu_a    = alu_a_reg;
    assign alu_b    = alu_b_reg;
    assign alu_op   = alu_op_reg;
    assign halted   = halted_reg;
    assign reg0     = rf[0];

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer: program table run to HALT against a small memory
// and ALU model, plus hand sequences for reset, jump wrap and wait-state behaviour.
module tb_alu_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] mem_addr;
    logic       mem_rd;
    logic       mem_ready;
    logic [7:0] mem_rdata;
    logic [7:0] alu_a;
    logic [7:0] alu_b;
    logic [3:0] alu_op;
    logic [7:0] alu_y;
    logic       halted;
    logic [7:0] reg0;

    alu_sequencer #(.RESET_PC(8'h00)) dut (
        .clk(clk), .rst(rst),
        .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_y(alu_y),
        .halted(halted), .reg0(reg0)
    );

    always #5 clk = ~clk;

    // ALU model: 0 AND, 1 OR, 2 NOT A, 3 XOR, 4 ADD, 5 SUB, 6 TX B, 7 SHR A by B[2:0].
    always_comb begin
        alu_y = 8'h00;
        case (alu_op)
            4'h0: alu_y = alu_a & alu_b;
            4'h1: alu_y = alu_a | alu_b;
            4'h2: alu_y = ~alu_a;
            4'h3: alu_y = alu_a ^ alu_b;
            4'h4: alu_y = alu_a + alu_b;
            4'h5: alu_y = alu_a - alu_b;
            4'h6: alu_y = alu_b;
            4'h7: alu_y = alu_a >> alu_b[2:0];
            default: alu_y = 8'hEE;
        endcase
    end

    // Memory with a configurable number of wait cycles per access.
    logic [7:0] mem [256];
    int         waits_cfg = 0;
    int         wait_cnt = 0;
    assign mem_rdata = mem[mem_addr];
    assign mem_ready = (wait_cnt >= waits_cfg);

    always @(posedge clk) begin
        if (!mem_rd || mem_ready) wait_cnt <= 0;
        else                      wait_cnt <= wait_cnt + 1;
    end

    // Last completed access address, and stability of mem_rd/mem_addr while stalled.
    logic [7:0] last_addr = 8'h00;
    logic       stall_pend = 1'b0;
    logic [7:0] stall_addr = 8'h00;
    int         stall_checks = 0;
    int         stall_bad = 0;

    always @(posedge clk) begin
        if (mem_rd && mem_ready) last_addr <= mem_addr;
        if (stall_pend && !rst) begin
            stall_checks <= stall_checks + 1;
            if (!mem_rd || mem_addr != stall_addr) stall_bad <= stall_bad + 1;
        end
        stall_pend <= mem_rd && !mem_ready;
        stall_addr <= mem_addr;
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic load(input logic [95:0] prog);
        for (int i = 0; i < 256; i++) mem[i] = 8'hF0;
        for (int i = 0; i < 12; i++) mem[i] = prog[95-8*i -: 8];
    endtask

    task automatic reset_dut();
        rst = 1'b1;
        step(2);
        rst = 1'b0;
    endtask

    task automatic run_to_halt(output int cycles);
        cycles = 0;
        for (int i = 0; i < 400; i++) begin
            step(1);
            cycles++;
            if (halted) break;
        end
    endtask

    typedef struct {
        string       name;
        logic [95:0] prog;
        int          waits;
        logic [7:0]  exp_r0;
        logic [7:0]  exp_last;
        int          exp_cycles;
    } vec_t;

    vec_t vecs[10];

    initial begin
        int cyc;

        vecs[0] = '{"arith",      96'h84_05_80_03_41_F0_F0_F0_F0_F0_F0_F0, 0, 8'h08, 8'h05, 11};
        vecs[1] = '{"arith_w3",   96'h84_05_80_03_41_F0_F0_F0_F0_F0_F0_F0, 3, 8'h08, 8'h05, 29};
        vecs[2] = '{"jz_taken",   96'h80_05_50_A0_20_C0_F0_F0_F0_F0_F0_F0, 0, 8'h00, 8'h20, 11};
        vecs[3] = '{"jz_taken_w2",96'h80_05_50_A0_20_C0_F0_F0_F0_F0_F0_F0, 2, 8'h00, 8'h20, 23};
        vecs[4] = '{"jz_not",     96'h80_01_C0_A0_20_F0_F0_F0_F0_F0_F0_F0, 0, 8'h01, 8'h05, 10};
        vecs[5] = '{"zero_kept",  96'h50_80_07_A0_08_F0_F0_F0_F0_F0_F0_F0, 0, 8'h07, 8'h08, 11};
        vecs[6] = '{"shr",        96'h84_F0_88_02_76_61_F0_F0_F0_F0_F0_F0, 0, 8'h3C, 8'h06, 14};
        vecs[7] = '{"not_nz",     96'h2C_63_A0_0A_F0_F0_F0_F0_F0_F0_F0_F0, 0, 8'hFF, 8'h04, 11};
        vecs[8] = '{"tx_self",    96'h84_AA_65_61_F0_F0_F0_F0_F0_F0_F0_F0, 0, 8'hAA, 8'h04, 11};
        vecs[9] = '{"add_wrap",   96'h80_FF_84_02_41_F0_F0_F0_F0_F0_F0_F0, 0, 8'h01, 8'h05, 11};

        // Reset state, then ALU operands during EXEC of the arithmetic program.
        load(96'h84_05_80_03_41_F0_F0_F0_F0_F0_F0_F0);
        waits_cfg = 0;
        rst = 1'b1;
        step(2);
        check("rst_mem_rd", mem_rd, 0);
        check("rst_halted", halted, 0);
        check("rst_reg0", reg0, 0);
        check("rst_alu", {alu_a, alu_b, alu_op}, 0);
        check("rst_addr", mem_addr, 8'h00);
        rst = 1'b0;
        #1;
        check("first_fetch", {mem_rd, mem_addr}, {1'b1, 8'h00});
        step(8);
        check("exec_operands", {alu_a, alu_b, alu_op}, {8'h03, 8'h05, 4'h4});
        check("exec_r0_before", reg0, 8'h03);
        step(1);
        check("exec_r0_after", reg0, 8'h08);
        check("exec_operands_hold", {alu_a, alu_b, alu_op}, {8'h03, 8'h05, 4'h4});
        step(1);
        check("halt_at_10", halted, 0);
        step(1);
        check("halt_at_11", halted, 1);
        check("halt_no_rd", mem_rd, 0);
        $display("seq exec_operands: a=%h b=%h op=%h r0=%h", alu_a, alu_b, alu_op, reg0);

        // Reset from HALT clears halted and restarts at RESET_PC.
        rst = 1'b1;
        step(1);
        check("halt_rst_clear", {halted, mem_rd}, 0);
        rst = 1'b0;
        #1;
        check("halt_rst_refetch", {mem_rd, mem_addr}, {1'b1, 8'h00});
        $display("seq halt_reset: halted=%b addr=%h", halted, mem_addr);

        // Table of whole programs run to HALT.
        foreach (vecs[k]) begin
            load(vecs[k].prog);
            waits_cfg = vecs[k].waits;
            reset_dut();
            run_to_halt(cyc);
            check({vecs[k].name, "_cycles"}, cyc, vecs[k].exp_cycles);
            check({vecs[k].name, "_r0"}, reg0, vecs[k].exp_r0);
            check({vecs[k].name, "_last"}, last_addr, vecs[k].exp_last);
            $display("vec %s: cycles=%0d r0=%h last_addr=%h", vecs[k].name, cyc, reg0, last_addr);
        end
        check("stall_seen", (stall_checks > 0), 1);
        check("stall_stable", stall_bad, 0);

        // JMP to FF, NOP at FF, next fetch wraps to 00.
        load(96'h90_FF_F0_F0_F0_F0_F0_F0_F0_F0_F0_F0);
        mem[255] = 8'hC0;
        waits_cfg = 0;
        reset_dut();
        step(3);
        check("jmp_ff", {mem_rd, mem_addr}, {1'b1, 8'hFF});
        step(2);
        check("nop_wrap", {mem_rd, mem_addr}, {1'b1, 8'h00});
        $display("seq jmp_wrap: addr=%h", mem_addr);

        // Reset while LDI operand access is stalled.
        load(96'h80_55_F0_F0_F0_F0_F0_F0_F0_F0_F0_F0);
        waits_cfg = 3;
        reset_dut();
        step(7);
        check("ldi_wait_rd", {mem_rd, mem_addr}, {1'b1, 8'h01});
        rst = 1'b1;
        #1;
        check("ldi_rst_rd", mem_rd, 0);
        step(2);
        check("ldi_rst_state", {reg0, mem_addr, halted}, {8'h00, 8'h00, 1'b0});
        rst = 1'b0;
        run_to_halt(cyc);
        check("ldi_restart_cycles", cyc, 14);
        check("ldi_restart_r0", reg0, 8'h55);
        $display("seq rst_oper_wait: cycles=%0d r0=%h", cyc, reg0);

        // Reset on the very edge the zero-wait LDI operand is ready: no write.
        waits_cfg = 0;
        reset_dut();
        step(2);
        check("ldi_ready_rd", {mem_rd, mem_addr, mem_ready}, {1'b1, 8'h01, 1'b1});
        rst = 1'b1;
        step(1);
        check("ldi_ready_nowrite", reg0, 8'h00);
        check("ldi_ready_pc", mem_addr, 8'h00);
        rst = 1'b0;
        $display("seq rst_oper_ready: r0=%h addr=%h", reg0, mem_addr);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
